// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional macro PIPE_FLUSH_NOP_EN: out_data loads NOP_VALUE whenever the stage becomes empty.
module pipe_stage_skid_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_nxt;
  logic [DATA_W-1:0] main_nxt;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_nxt;
  logic              accept;
  logic              emit;

  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
  assign occupancy = 2'(state_q);

  // State register; the encoding doubles as the held-entry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and slot contents; out_data is the main slot itself.
  always_comb begin
    state_nxt = state_q;
    main_nxt  = out_data;
    skid_nxt  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_nxt = HALF;
          main_nxt  = in_data;
        end
      end
      HALF: begin
        if (accept && emit) begin
          main_nxt = in_data;
        end else if (accept) begin
          state_nxt = FULL;
          skid_nxt  = in_data;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          state_nxt = HALF;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = EMPTY;
    endcase

    // Flush wins: drop any same-cycle accept; a same-cycle emit already left.
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = out_data;
    end

`ifdef PIPE_FLUSH_NOP_EN
    if ((state_nxt == EMPTY) && ((state_q != EMPTY) || flush)) begin
      main_nxt = NOP_VALUE;
    end
`endif
  end

  // Registered handshake outputs and payload slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      out_data  <= main_nxt;
      skid_q    <= skid_nxt;
      out_valid <= (state_nxt != EMPTY);
      in_ready  <= (state_nxt != FULL);
    end
  end

`ifndef PIPE_FLUSH_NOP_EN
  logic unused_nop_value;
  assign unused_nop_value = ^NOP_VALUE;
`endif

endmodule
